counter_updown_mod_nbit: RTL and testbench

Parametrised synchronous up/down modulo counter with parallel load, enable, a selectable wrap or saturate mode, a terminal-count strobe and a sticky overflow flag. It generalises the plain N-bit up counter for use as a programmable divider, event counter or timeout timer. It sits as a leaf block driven directly by the system clock. All state changes occur on the rising edge of `clk`, except for the asynchronous reset.

---
 rtl/counter_updown_mod_nbit.sv | 82 ++++++++
 tb/tb_counter_updown_mod_nbit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_updown_mod_nbit.sv
// Up/down modulo-MOD counter with clamped parallel load, wrap or saturate at the
// range limits, a combinational terminal-count strobe and a sticky overflow flag.
module counter_updown_mod_nbit #(
  parameter int N   = 4,
  parameter int MOD = 16,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         sclr,
  input  logic         ovf_clr,
  output logic [N-1:0] count,
  output logic         tc,
  output logic         ovf
);

  // The modulus may equal 2^N, so only the top value MOD-1 is guaranteed to fit in N bits.
  localparam logic [N-1:0] MAX_VAL  = N'(MOD - 1);
  localparam logic [N-1:0] ONE      = N'(1);
  localparam logic [N-1:0] ZERO_VAL = '0;

  logic [N-1:0] count_reg, count_next;
  logic         ovf_reg, ovf_next;
  logic         at_max, at_zero;
  logic         step_cmd;

  assign at_max   = (count_reg == MAX_VAL);
  assign at_zero  = (count_reg == ZERO_VAL);
  assign step_cmd = en & ~sclr & ~load;

  assign tc = step_cmd & ((up & at_max) | (~up & at_zero));

  always_comb begin
    count_next = count_reg;
    if (sclr) begin
      count_next = ZERO_VAL;
    end else if (load) begin
      count_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      if (up) begin
        if (!at_max)
          count_next = count_reg + ONE;
        else
          count_next = SAT ? MAX_VAL : ZERO_VAL;
      end else begin
        if (!at_zero)
          count_next = count_reg - ONE;
        else
          count_next = SAT ? ZERO_VAL : MAX_VAL;
      end
    end
  end

  // A terminal-count event outranks a same-cycle ovf_clr.
  always_comb begin
    ovf_next = ovf_reg;
    if (sclr)
      ovf_next = 1'b0;
    else if (tc)
      ovf_next = 1'b1;
    else if (ovf_clr)
      ovf_next = 1'b0;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign count = count_reg;
  assign ovf   = ovf_reg;

endmodule

// File: tb/tb_counter_updown_mod_nbit.sv
// Directed bench for counter_updown_mod_nbit: wrap (4/10), saturate (4/10) and
// wide (7/128) instances share one clock; inputs change on the falling edge.
module tb_counter_updown_mod_nbit;

  logic clk;
  int   n_tests;
  int   n_fail;

  // wrap instance, N=4 MOD=10
  logic       clr_n_a, en_a, up_a, load_a, sclr_a, ovf_clr_a;
  logic [3:0] load_val_a, count_a;
  logic       tc_a, ovf_a;
  // saturate instance, N=4 MOD=10
  logic       clr_n_s, en_s, up_s, load_s, sclr_s, ovf_clr_s;
  logic [3:0] load_val_s, count_s;
  logic       tc_s, ovf_s;
  // wide wrap instance, N=7 MOD=128
  logic       clr_n_w, en_w, up_w, load_w, sclr_w, ovf_clr_w;
  logic [6:0] load_val_w, count_w;
  logic       tc_w, ovf_w;

  counter_updown_mod_nbit #(.N(4), .MOD(10), .SAT(1'b0)) dut_a (
    .clk(clk), .clr_n(clr_n_a), .en(en_a), .up(up_a), .load(load_a),
    .load_val(load_val_a), .sclr(sclr_a), .ovf_clr(ovf_clr_a),
    .count(count_a), .tc(tc_a), .ovf(ovf_a)
  );

  counter_updown_mod_nbit #(.N(4), .MOD(10), .SAT(1'b1)) dut_s (
    .clk(clk), .clr_n(clr_n_s), .en(en_s), .up(up_s), .load(load_s),
    .load_val(load_val_s), .sclr(sclr_s), .ovf_clr(ovf_clr_s),
    .count(count_s), .tc(tc_s), .ovf(ovf_s)
  );

  counter_updown_mod_nbit #(.N(7), .MOD(128), .SAT(1'b0)) dut_w (
    .clk(clk), .clr_n(clr_n_w), .en(en_w), .up(up_w), .load(load_w),
    .load_val(load_val_w), .sclr(sclr_w), .ovf_clr(ovf_clr_w),
    .count(count_w), .tc(tc_w), .ovf(ovf_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    clr_n_a = 0; en_a = 0; up_a = 0; load_a = 0; sclr_a = 0; ovf_clr_a = 0; load_val_a = 0;
    clr_n_s = 0; en_s = 0; up_s = 0; load_s = 0; sclr_s = 0; ovf_clr_s = 0; load_val_s = 0;
    clr_n_w = 0; en_w = 0; up_w = 0; load_w = 0; sclr_w = 0; ovf_clr_w = 0; load_val_w = 0;
    tick(); tick();
    n_tests++;
    if (count_a !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count_a); end
    n_tests++;
    if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf_a); end
    n_tests++;
    if (tc_a !== 1'b0) begin n_fail++; $display("FAIL reset_tc: got %b expected 0", tc_a); end
    clr_n_a = 1; clr_n_s = 1; clr_n_w = 1;
    $display("[TB] reset: count=%0d ovf=%b", count_a, ovf_a);
  endtask

  task automatic test_up_wrap();
    logic [3:0] exp_cnt;
    logic       exp_tc;
    en_a = 1; up_a = 1;
    for (int i = 1; i <= 10; i++) begin
      #1;
      exp_tc = (i == 10);
      n_tests++;
      if (tc_a !== exp_tc) begin n_fail++; $display("FAIL up_wrap_tc step %0d: got %b expected %b", i, tc_a, exp_tc); end
      tick();
      exp_cnt = 4'(i % 10);
      n_tests++;
      if (count_a !== exp_cnt) begin n_fail++; $display("FAIL up_wrap_count step %0d: got %0d expected %0d", i, count_a, exp_cnt); end
      if (i == 9) begin
        n_tests++;
        if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL up_wrap_ovf_early: got %b expected 0", ovf_a); end
      end
      $display("[TB] up_wrap step %0d: count=%0d tc=%b ovf=%b", i, count_a, tc_a, ovf_a);
    end
    n_tests++;
    if (ovf_a !== 1'b1) begin n_fail++; $display("FAIL up_wrap_ovf: got %b expected 1", ovf_a); end
  endtask

  task automatic test_down_wrap();
    up_a = 0; en_a = 1;
    #1;
    n_tests++;
    if (tc_a !== 1'b1) begin n_fail++; $display("FAIL down_tc_at0: got %b expected 1", tc_a); end
    tick();
    n_tests++;
    if (count_a !== 4'd9) begin n_fail++; $display("FAIL down_wrap_count: got %0d expected 9", count_a); end
    #1;
    n_tests++;
    if (tc_a !== 1'b0) begin n_fail++; $display("FAIL down_tc_at9: got %b expected 0", tc_a); end
    tick();
    n_tests++;
    if (count_a !== 4'd8) begin n_fail++; $display("FAIL down_count_8: got %0d expected 8", count_a); end
    n_tests++;
    if (ovf_a !== 1'b1) begin n_fail++; $display("FAIL down_ovf: got %b expected 1", ovf_a); end
    en_a = 0; ovf_clr_a = 1;
    tick();
    ovf_clr_a = 0;
    n_tests++;
    if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b expected 0", ovf_a); end
    n_tests++;
    if (count_a !== 4'd8) begin n_fail++; $display("FAIL ovf_clr_hold: got %0d expected 8", count_a); end
    $display("[TB] down_wrap: count=%0d ovf=%b", count_a, ovf_a);
  endtask

  task automatic test_saturate();
    logic exp_tc;
    load_s = 1; load_val_s = 4'd8;
    tick();
    load_s = 0;
    n_tests++;
    if (count_s !== 4'd8) begin n_fail++; $display("FAIL sat_load: got %0d expected 8", count_s); end
    en_s = 1; up_s = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_tc = (k > 0);
      n_tests++;
      if (tc_s !== exp_tc) begin n_fail++; $display("FAIL sat_up_tc step %0d: got %b expected %b", k, tc_s, exp_tc); end
      tick();
      n_tests++;
      if (count_s !== 4'd9) begin n_fail++; $display("FAIL sat_up_count step %0d: got %0d expected 9", k, count_s); end
      $display("[TB] sat_up step %0d: count=%0d ovf=%b", k, count_s, ovf_s);
    end
    n_tests++;
    if (ovf_s !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: got %b expected 1", ovf_s); end
    en_s = 0; load_s = 1; load_val_s = 4'd1;
    tick();
    load_s = 0; en_s = 1; up_s = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      exp_tc = (k > 0);
      n_tests++;
      if (tc_s !== exp_tc) begin n_fail++; $display("FAIL sat_dn_tc step %0d: got %b expected %b", k, tc_s, exp_tc); end
      tick();
      n_tests++;
      if (count_s !== 4'd0) begin n_fail++; $display("FAIL sat_dn_count step %0d: got %0d expected 0", k, count_s); end
      $display("[TB] sat_down step %0d: count=%0d ovf=%b", k, count_s, ovf_s);
    end
    en_s = 0;
  endtask

  task automatic test_load_clamp();
    load_a = 1; load_val_a = 4'd13; en_a = 1; up_a = 1;
    #1;
    n_tests++;
    if (tc_a !== 1'b0) begin n_fail++; $display("FAIL clamp_tc: got %b expected 0", tc_a); end
    tick();
    load_a = 0;
    n_tests++;
    if (count_a !== 4'd9) begin n_fail++; $display("FAIL clamp_count: got %0d expected 9", count_a); end
    n_tests++;
    if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL load_ovf_unchanged: got %b expected 0", ovf_a); end
    tick();
    n_tests++;
    if (ovf_a !== 1'b1 || count_a !== 4'd0) begin n_fail++; $display("FAIL clamp_wrap: got count=%0d ovf=%b expected count=0 ovf=1", count_a, ovf_a); end
    en_a = 0; load_a = 1; load_val_a = 4'd4;
    tick();
    n_tests++;
    if (count_a !== 4'd4) begin n_fail++; $display("FAIL load_4: got %0d expected 4", count_a); end
    sclr_a = 1; load_a = 1; load_val_a = 4'd7; en_a = 1; up_a = 1;
    tick();
    sclr_a = 0; load_a = 0; en_a = 0;
    n_tests++;
    if (count_a !== 4'd0 || ovf_a !== 1'b0) begin n_fail++; $display("FAIL sclr_priority: got count=%0d ovf=%b expected count=0 ovf=0", count_a, ovf_a); end
    $display("[TB] load_clamp: count=%0d ovf=%b", count_a, ovf_a);
  endtask

  task automatic test_simultaneous();
    load_a = 1; load_val_a = 4'd9;
    tick();
    load_a = 0; en_a = 1; up_a = 1; ovf_clr_a = 1;
    #1;
    n_tests++;
    if (tc_a !== 1'b1) begin n_fail++; $display("FAIL simul_tc: got %b expected 1", tc_a); end
    tick();
    en_a = 0; ovf_clr_a = 0;
    n_tests++;
    if (count_a !== 4'd0 || ovf_a !== 1'b1) begin n_fail++; $display("FAIL simul_set_wins: got count=%0d ovf=%b expected count=0 ovf=1", count_a, ovf_a); end
    load_a = 1; load_val_a = 4'd9;
    tick();
    load_a = 0; en_a = 0; up_a = 1;
    #1;
    n_tests++;
    if (tc_a !== 1'b0) begin n_fail++; $display("FAIL hold_tc: got %b expected 0", tc_a); end
    tick(); tick();
    n_tests++;
    if (count_a !== 4'd9) begin n_fail++; $display("FAIL hold_count: got %0d expected 9", count_a); end
    $display("[TB] simultaneous: count=%0d ovf=%b", count_a, ovf_a);
  endtask

  task automatic test_async_reset();
    en_w = 1; up_w = 1;
    for (int i = 0; i < 57; i++) tick();
    n_tests++;
    if (count_w !== 7'd57) begin n_fail++; $display("FAIL wide_count57: got %0d expected 57", count_w); end
    #2;
    clr_n_w = 0;
    #1;
    n_tests++;
    if (count_w !== 7'd0 || ovf_w !== 1'b0) begin n_fail++; $display("FAIL async_reset: got count=%0d ovf=%b expected count=0 ovf=0", count_w, ovf_w); end
    tick();
    clr_n_w = 1;
    tick();
    n_tests++;
    if (count_w !== 7'd1) begin n_fail++; $display("FAIL resume_1: got %0d expected 1", count_w); end
    tick();
    n_tests++;
    if (count_w !== 7'd2) begin n_fail++; $display("FAIL resume_2: got %0d expected 2", count_w); end
    en_w = 0;
    $display("[TB] async_reset: count=%0d ovf=%b", count_w, ovf_w);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    @(negedge clk);
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_saturate();
    test_load_clamp();
    test_simultaneous();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
